// File: rtl/leaky_relu_grad.sv
// Leaky-ReLU backward pass: pairs each upstream gradient with the forward-pass
// sign mask held in a FIFO and scales negative-side gradients by 2^-SHIFT.
module leaky_relu_grad #(
    parameter int DATA_WIDTH = 16,
    parameter int SHIFT      = 7,
    parameter int MASK_DEPTH = 16   // power of 2, at least 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,

    input  logic                          mask_valid,
    input  logic                          mask_in,
    output logic                          mask_ready,

    input  logic                          grad_valid,
    input  logic signed [DATA_WIDTH-1:0]  grad_in,
    output logic                          grad_ready,

    output logic                          out_valid,
    output logic signed [DATA_WIDTH-1:0]  out_data,
    input  logic                          out_ready,

    output logic [$clog2(MASK_DEPTH):0]   mask_count
);

    localparam int AW = $clog2(MASK_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(MASK_DEPTH);

    logic [MASK_DEPTH-1:0]        mask_mem;
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic                         push;
    logic                         pop;
    logic                         cur_mask;
    logic signed [DATA_WIDTH-1:0] result;

    // Handshakes depend only on registered state and out_ready.
    always_comb begin
        mask_ready = (mask_count < DEPTH_C);
        grad_ready = (mask_count != '0) && (!out_valid || out_ready);
    end

    always_comb begin
        push     = mask_valid && mask_ready;
        pop      = grad_valid && grad_ready;
        cur_mask = mask_mem[rd_ptr];
        result   = cur_mask ? (grad_in >>> SHIFT) : grad_in;
    end

    // Mask storage is not reset; occupancy tracking alone guards validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mask_mem[wr_ptr] <= mask_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mask_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mask_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   mask_count <= mask_count + CW'(1);
                2'b01:   mask_count <= mask_count - CW'(1);
                default: mask_count <= mask_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= result;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_leaky_relu_grad.sv
// Directed bench for leaky_relu_grad with hand-computed expectations
// (default parameters: 16-bit data, SHIFT 7, 16-entry mask FIFO).
module tb_leaky_relu_grad;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic               mask_valid;
    logic               mask_in;
    logic               mask_ready;
    logic               grad_valid;
    logic signed [15:0] grad_in;
    logic               grad_ready;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic               out_ready;
    logic [4:0]         mask_count;

    int errors = 0;
    int checks = 0;

    leaky_relu_grad #(
        .DATA_WIDTH(16),
        .SHIFT(7),
        .MASK_DEPTH(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .mask_valid(mask_valid),
        .mask_in(mask_in),
        .mask_ready(mask_ready),
        .grad_valid(grad_valid),
        .grad_in(grad_in),
        .grad_ready(grad_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .mask_count(mask_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        mask_valid = 1'b0;
        mask_in    = 1'b0;
        grad_valid = 1'b0;
        grad_in    = '0;
        out_ready  = 1'b1;

        // Reset state, before any clock edge
        #2;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_count", 32'(mask_count), 0);
        check("rst_mask_ready", 32'(mask_ready), 1);
        check("rst_grad_ready", 32'(grad_ready), 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Masks 0,1,1 then grads 100,-128,-1 back to back
        mask_valid = 1'b1;
        mask_in = 1'b0; step();
        mask_in = 1'b1; step();
        step();
        mask_valid = 1'b0;
        check("seq_count3", 32'(mask_count), 3);
        grad_valid = 1'b1;
        grad_in = 16'sd100; step();
        check("seq_v0", 32'(out_valid), 1);
        check("seq_d0", 32'(out_data), 100);
        grad_in = -16'sd128; step();
        check("seq_v1", 32'(out_valid), 1);
        check("seq_d1", 32'(out_data), -1);
        grad_in = -16'sd1; step();
        check("seq_v2", 32'(out_valid), 1);
        check("seq_d2", 32'(out_data), -1);
        grad_valid = 1'b0;
        check("seq_count0", 32'(mask_count), 0);
        step();
        check("seq_idle", 32'(out_valid), 0);

        // Mask 1 edge values: 127 -> 0, -32768 -> -256
        mask_valid = 1'b1; mask_in = 1'b1;
        step(); step();
        mask_valid = 1'b0;
        grad_valid = 1'b1;
        grad_in = 16'sd127; step();
        check("edge_127", 32'(out_data), 0);
        grad_in = -16'sd32768; step();
        check("edge_min", 32'(out_data), -256);
        grad_valid = 1'b0;
        step();

        // Fill 16 masks (pattern i[0]), 17th ignored, pop+push at full -> 15
        mask_valid = 1'b1;
        for (int unsigned i = 0; i < 16; i++) begin
            mask_in = i[0];
            step();
        end
        check("full_count", 32'(mask_count), 16);
        check("full_mready", 32'(mask_ready), 0);
        mask_in = 1'b1;
        step();
        check("full_17th", 32'(mask_count), 16);
        check("full_gready", 32'(grad_ready), 1);
        grad_valid = 1'b1; grad_in = 16'sd1000;
        step();
        mask_valid = 1'b0; grad_valid = 1'b0;
        check("full_poppush", 32'(mask_count), 15);
        check("full_pop_data", 32'(out_data), 1000);
        step();

        // Backpressure: result held for 5 cycles, then transfer + next accept
        out_ready = 1'b0;
        grad_valid = 1'b1; grad_in = -16'sd200;
        step();
        check("bp_first", 32'(out_data), -2);
        grad_in = 16'sd300;
        for (int unsigned i = 0; i < 5; i++) begin
            step();
            check("bp_hold_v", 32'(out_valid), 1);
            check("bp_hold_d", 32'(out_data), -2);
            check("bp_gready", 32'(grad_ready), 0);
        end
        check("bp_count", 32'(mask_count), 14);
        out_ready = 1'b1;
        #1;
        check("bp_release_gready", 32'(grad_ready), 1);
        step();
        check("bp_next_v", 32'(out_valid), 1);
        check("bp_next_d", 32'(out_data), 300);
        check("bp_next_count", 32'(mask_count), 13);
        grad_valid = 1'b0;
        step();
        check("bp_drain", 32'(out_valid), 0);

        // Flush the remaining 13, then empty-FIFO no-bypass check
        flush = 1'b1; step(); flush = 1'b0;
        check("flush1_count", 32'(mask_count), 0);
        grad_valid = 1'b1; grad_in = 16'sd500;
        check("nb_gready_empty", 32'(grad_ready), 0);
        mask_valid = 1'b1; mask_in = 1'b1;
        step();
        mask_valid = 1'b0;
        check("nb_not_at_t", 32'(out_valid), 0);
        check("nb_count1", 32'(mask_count), 1);
        check("nb_gready", 32'(grad_ready), 1);
        step();
        check("nb_at_t1_v", 32'(out_valid), 1);
        check("nb_at_t1_d", 32'(out_data), 3);
        check("nb_count0", 32'(mask_count), 0);
        grad_valid = 1'b0;
        step();

        // Flush with 5 masks held and out_valid=1; push during flush ignored
        mask_valid = 1'b1; mask_in = 1'b0;
        repeat (6) step();
        mask_valid = 1'b0;
        out_ready = 1'b0;
        grad_valid = 1'b1; grad_in = 16'sd7;
        step();
        grad_valid = 1'b0;
        check("fl_pre_count", 32'(mask_count), 5);
        check("fl_pre_valid", 32'(out_valid), 1);
        check("fl_pre_data", 32'(out_data), 7);
        flush = 1'b1; mask_valid = 1'b1;
        step();
        flush = 1'b0; mask_valid = 1'b0;
        check("fl_count", 32'(mask_count), 0);
        check("fl_valid", 32'(out_valid), 0);
        out_ready = 1'b1;

        // Asynchronous reset mid-stream
        mask_valid = 1'b1; mask_in = 1'b1;
        step(); step();
        mask_valid = 1'b0;
        grad_valid = 1'b1; grad_in = 16'sd1280;
        step();
        grad_valid = 1'b0;
        check("ar_pre_data", 32'(out_data), 10);
        check("ar_pre_count", 32'(mask_count), 1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 0);
        check("ar_data", 32'(out_data), 0);
        check("ar_count", 32'(mask_count), 0);
        check("ar_mready", 32'(mask_ready), 1);
        check("ar_gready", 32'(grad_ready), 0);
        step();
        rst_n = 1'b1;
        mask_valid = 1'b1; mask_in = 1'b0;
        step();
        mask_valid = 1'b0;
        check("ar_post_count", 32'(mask_count), 1);
        grad_valid = 1'b1; grad_in = -16'sd5;
        step();
        grad_valid = 1'b0;
        check("ar_post_data", 32'(out_data), -5);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/leaky_relu_grad.md
LEAKY_RELU_GRAD -- requirements
Module: leaky_relu_grad

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the signed gradient word width.
REQ-002 The block SHALL have parameter SHIFT, default 7, giving the negative-slope alpha = 2^-SHIFT.
REQ-003 The block SHALL have parameter MASK_DEPTH, default 16, giving the sign-mask FIFO depth; it SHALL be a power of 2 and at least 2.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 is the rising-edge clock; rst_n input 1 is the asynchronous active-low reset.
REQ-005 The block SHALL have the port flush, input, 1 bit: synchronous clear of all buffered state.
REQ-006 The block SHALL have the mask port: mask_valid input 1; mask_in input 1, the forward-pass sign with 1 meaning forward x was negative; mask_ready output 1.
REQ-007 The block SHALL have the gradient input port: grad_valid input 1; grad_in input DATA_WIDTH signed, the upstream gradient; grad_ready output 1.
REQ-008 The block SHALL have the output port: out_valid output 1; out_data output DATA_WIDTH signed, the downstream gradient; out_ready input 1.
REQ-009 The block SHALL have the status port mask_count, output, clog2(MASK_DEPTH)+1 bits: number of masks held in the FIFO.

Function
REQ-010 A mask SHALL be pushed into the FIFO on a rising edge where mask_valid && mask_ready.
REQ-011 mask_ready SHALL equal (mask_count < MASK_DEPTH); there is no push-while-full bypass, even when a pop occurs in the same cycle.
REQ-012 grad_ready SHALL equal (mask_count > 0) && (!out_valid || out_ready).
REQ-013 A mask pushed into an empty FIFO SHALL NOT be usable until the following cycle; there is no write-to-read bypass.
REQ-014 A gradient SHALL be accepted on a rising edge where grad_valid && grad_ready; the accepted gradient SHALL pop exactly one mask, and gradients SHALL pair with masks in FIFO order.
REQ-015 When the popped mask is 1, the result SHALL be grad_in >>> SHIFT (arithmetic, truncating toward -infinity); when the popped mask is 0, the result SHALL be grad_in unchanged.
REQ-016 The result SHALL be registered into out_data, with out_valid asserted on the cycle after acceptance (latency 1).
REQ-017 out_valid and out_data SHALL hold stable while out_valid && !out_ready.
REQ-018 out_valid SHALL clear after a transfer unless a new gradient is accepted on the same edge; back-to-back transfers SHALL sustain 1 result per cycle.
REQ-019 mask_count SHALL increment by 1 on a push only, decrement by 1 on a pop only, and stay unchanged on a simultaneous push and pop.
REQ-020 The FIFO read and write pointers SHALL wrap modulo MASK_DEPTH.
REQ-021 While flush=1 on a rising edge, the block SHALL set mask_count to 0, reset both pointers, clear out_valid, and ignore pushes and accepts in that cycle.
REQ-022 mask_ready and grad_ready SHALL be combinational functions of registered state and out_ready only; they SHALL NOT depend on mask_valid or grad_valid.
REQ-023 The block SHALL NOT saturate: the shift result always fits in DATA_WIDTH.

Reset
REQ-024 While rst_n=0, the block SHALL asynchronously force out_valid=0, out_data=0, mask_count=0, and both pointers to 0.
REQ-025 While rst_n=0, mask_ready SHALL be 1 and grad_ready SHALL be 0.
REQ-026 Deassertion of rst_n SHALL take effect at the next rising clk edge.
REQ-027 An rst_n assertion mid-transfer SHALL discard any pending output and all buffered masks.
REQ-028 FIFO storage contents need not be reset.

Verification
REQ-029 The bench SHALL cover mask sequence 0,1,1 then grads 100,-128,-1 with out_ready=1 -> outputs 100, -1, -1 on consecutive cycles; mask_count ends 0.
REQ-030 The bench SHALL cover mask 1 with grad 127 -> output 0; mask 1 with grad -32768 -> output -256.
REQ-031 The bench SHALL cover pushing 16 masks -> mask_ready=0 at count 16; a 17th push is ignored; a simultaneous pop and push attempt at full leaves count 15.
REQ-032 The bench SHALL cover out_ready=0 for 5 cycles while out_valid=1 -> out_data stable, grad_ready=0; on release, one transfer, then next accept.
REQ-033 The bench SHALL cover FIFO empty with grad_valid=1 and mask pushed at cycle t -> grad accepted at t+1, not at t.
REQ-034 The bench SHALL cover flush with 5 masks held and out_valid=1 -> next cycle count 0, out_valid 0; rst_n pulse mid-stream -> all outputs 0 immediately, without a clock edge.
